seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 4-bit "1101" Moore detector.
//  - Runtime-loadable pattern of PAT_W bits, with input qualified by din_valid.
//  - Selectable overlapping or non-overlapping detection.
//  - Optional saturating match counter.
//  - Sits on a serial bit stream (e.g. deserialiser/framer front end) and flags sync-word hits.
// PARAMETERS
//  PAT_W        4         pattern length in bits; legal range 2..32
//  DEFAULT_PAT  4'b1101   pattern value loaded at reset; PAT_W bits, MSB = oldest bit
//  CNT_W        8         match counter width; only used with SEQ_DET_MATCH_CNT_EN
// PORTS
//  clk        in   1       clock; all state updates on its rising edge
//  reset      in   1       asynchronous, active-high reset
//  din_valid  in   1       din carries a stream bit this cycle
//  din        in   1       serial input bit; ignored when din_valid=0
//  overlap_en in   1       1 = overlapping detection, 0 = non-overlapping; sampled on each valid beat
//  pat_load   in   1       single-cycle strobe: load pat_in and flush history
//  pat_in     in   PAT_W   new pattern; MSB = first bit expected on the stream
//  cnt_clr    in   1       synchronous clear of match_cnt
//  dout       out  1       registered single-cycle match pulse
//  match_cnt  out  CNT_W   saturating count of matches
// BEHAVIOUR
//  - State:
//      pattern [PAT_W]
//      hist    [PAT_W] shift register
//      fill    0..PAT_W, count of valid bits since last flush
//      dout, match_cnt
//  - Reset (async): pattern=DEFAULT_PAT, hist=0, fill=0, dout=0, match_cnt=0.
//  - Valid beat (din_valid=1, pat_load=0):
//      hist_n = {hist[PAT_W-2:0], din}
//      fill_n = min(fill+1, PAT_W)
//      match  = (fill_n==PAT_W) && (hist_n==pattern)
//  - On match with overlap_en=1: fill stays PAT_W, so the suffix can start the next match.
//  - On match with overlap_en=0: fill is cleared to 0, so the next match needs PAT_W fresh bits.
//  - dout (Moore-style, registered):
//      dout <= match, i.e. high the cycle after the beat carrying the last pattern bit;
//      high for exactly one cycle per match;
//      0 after any non-valid or non-matching cycle.
//  - Latency: 1 clk from the final bit to dout.
//  - Idle (din_valid=0): hist and fill hold; dout <= 0; bubbles never break a partial match.
//  - pat_load=1: pattern <= pat_in, hist <= 0, fill <= 0, dout <= 0.
//      A din_valid beat in the same cycle is discarded (load has priority).
//      Detection resumes on the next beat against the new pattern.
//  - Partial-history matches before fill==PAT_W are never reported, even if pattern has leading zeros.
//  - Reset mid-stream: history lost, pattern reverts to DEFAULT_PAT, no spurious dout on release.
//  - overlap_en change mid-stream: takes effect from the next valid beat; no flush.
// CONFIGURATION
//  - SEQ_DET_MATCH_CNT_EN defined:
//      match_cnt increments by 1 on each cycle dout is high, saturating at 2^CNT_W-1;
//      cnt_clr clears it to 0 and has priority over a coincident increment.
//  - SEQ_DET_MATCH_CNT_EN not defined:
//      match_cnt tied to 0, cnt_clr ignored, no counter flops.
//  - Ports are identical in both builds.
// STRUCTURE
//  - Package seq_det_pkg:
//      PAT_W_MIN=2, PAT_W_MAX=32
//      DEFAULT_PAT_1101 constant
//      overlap mode typedef (OVL_OFF / OVL_ON)
//  - Sub-module seq_det_sat_counter (WIDTH, inc, clr; clr priority):
//      instantiated only under SEQ_DET_MATCH_CNT_EN.
//  - Top holds the shift register, fill counter, compare and dout register.
// TESTING
//  1. Reset, PAT_W=4, overlap_en=1, stream 1,1,0,1,1,0,1 on consecutive cycles -> dout pulses 1 clk after bits 4 and 7 (2 matches).
//  2. Same stream, overlap_en=0 -> single dout pulse after bit 4; match_cnt=1 with the macro, 0 without.
//  3. Stream 1,1,0 then din_valid=0 for 3 cycles then 1 -> dout=1 one clk after the final valid beat; no pulse during the bubbles.
//  4. pat_load with pat_in=4'b0110, then 0,1,1,0 -> one match. A 1 presented with din_valid on the load cycle is discarded.
//  5. Assert reset after 1,1,0 mid-stream; after release send 1 -> no dout; pattern reads back 1101 via a later full match.
//  6. CNT_W=2 with the macro: 5 matches -> match_cnt saturates at 3. Match coincident with cnt_clr -> match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 32;

    localparam logic [3:0] DEFAULT_PAT_1101 = 4'b1101;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

endpackage : seq_det_pkg

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a coincident increment.
module seq_det_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : seq_det_sat_counter

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned       PAT_W       = 4,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(DEFAULT_PAT_1101),
    parameter int unsigned       CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned        FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of range");
    end

    logic [PAT_W-1:0]  pattern, pattern_d;
    logic [PAT_W-1:0]  hist, hist_d, hist_shift;
    logic [FILL_W-1:0] fill, fill_d, fill_inc;
    logic              match_c;
    ovl_mode_e         ovl_mode;

    assign ovl_mode   = ovl_mode_e'(overlap_en);
    assign hist_shift = {hist[PAT_W-2:0], din};
    assign fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);

    // Load has priority over a same-cycle beat; idle cycles hold history.
    always_comb begin
        pattern_d = pattern;
        hist_d    = hist;
        fill_d    = fill;
        match_c   = 1'b0;
        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (din_valid) begin
            hist_d  = hist_shift;
            match_c = (fill_inc == FILL_FULL) && (hist_shift == pattern);
            fill_d  = (match_c && (ovl_mode == OVL_OFF)) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= DEFAULT_PAT;
            hist    <= '0;
            fill    <= '0;
            dout    <= 1'b0;
        end else begin
            pattern <= pattern_d;
            hist    <= hist_d;
            fill    <= fill_d;
            dout    <= match_c;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dout),
        .clr   (cnt_clr),
        .count (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=4, CNT_W=2).
module tb_seq_detector_param;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic             din;
    logic             overlap_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;

    int passed = 0;
    int total  = 0;

    seq_detector_param #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (4'b1101),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .cnt_clr    (cnt_clr),
        .dout       (dout),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef SEQ_DET_MATCH_CNT_EN
        return (n > 3) ? 2'd3 : CNT_W'(n);
`else
        return (n > 0) ? 2'd0 : 2'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string tag, input logic [31:0] bits,
                           input logic [31:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            chk($sformatf("%s_bit%0d", tag, n - i), 32'(dout), 32'(exp[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din_valid = 1'b0; din = 1'b0; overlap_en = 1'b1;
        pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        reset = 1'b0;

        // 1: overlapping, matches after bits 4 and 7
        overlap_en = 1'b1;
        run_seq("t1", 32'b1101101, 32'b0001001, 7);
        step(1'b0, 1'b0);
        chk("t1_idle_dout", 32'(dout), 32'd0);
        chk("t1_cnt", 32'(match_cnt), 32'(exp_cnt(2)));

        // 2: non-overlapping, single match
        do_reset();
        overlap_en = 1'b0;
        run_seq("t2", 32'b1101101, 32'b0001000, 7);
        step(1'b0, 1'b0);
        chk("t2_cnt", 32'(match_cnt), 32'(exp_cnt(1)));

        // 3: bubbles do not break a partial match
        do_reset();
        overlap_en = 1'b1;
        run_seq("t3_pre", 32'b110, 32'b000, 3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk($sformatf("t3_bubble%0d", i), 32'(dout), 32'd0);
        end
        run_seq("t3_last", 32'b1, 32'b1, 1);

        // 4: load 0110; the valid 1 on the load cycle is discarded
        pat_load = 1'b1; pat_in = 4'b0110;
        step(1'b1, 1'b1);
        pat_load = 1'b0;
        chk("t4_load_dout", 32'(dout), 32'd0);
        run_seq("t4", 32'b0110, 32'b0001, 4);
        // discarded 0 plus 1,1,0 would complete 0110; also no partial-history hit
        pat_load = 1'b1;
        step(1'b1, 1'b0);
        pat_load = 1'b0;
        run_seq("t4_discard", 32'b110, 32'b000, 3);

        // 5: reset mid-stream restores default pattern 1101
        reset = 1'b1;
        #2;
        chk("t5_rst_dout", 32'(dout), 32'd0);
        step(1'b0, 1'b0);
        reset = 1'b0;
        run_seq("t5", 32'b1101, 32'b0001, 4);
        step(1'b0, 1'b0);
        chk("t5_pulse_end", 32'(dout), 32'd0);

        // 6: five overlapping matches saturate a 2-bit counter; clear beats increment
        do_reset();
        overlap_en = 1'b1;
        run_seq("t6", 32'b1101101101101101, 32'b0001001001001001, 16);
        step(1'b0, 1'b0);
        chk("t6_sat", 32'(match_cnt), 32'(exp_cnt(5)));
        run_seq("t6_more", 32'b101, 32'b001, 3);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("t6_clr_prio", 32'(match_cnt), 32'd0);
        run_seq("t6_after", 32'b101, 32'b001, 3);
        step(1'b0, 1'b0);
        chk("t6_recount", 32'(match_cnt), 32'(exp_cnt(1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_seq_detector_param
